apb_requester: RTL

APB4 requester (initiator) that turns single read/write commands from a valid/ready command port into APB SETUP/ACCESS transfers. It drives the signals that the slave-side register/FIFO block samples: PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA and PSTRB. It returns PRDATA/PSLVERR on a valid/ready response port, and a per-transfer timeout guards against a slave that never asserts PREADY. It sits between an internal control engine and the APB slave bus and replaces the bench-side DRIVE role in synthesizable RTL.

---
 rtl/apb_requester_if.sv | 26 ++
 rtl/apb_requester.sv | 118 +++++++++++
 2 files changed

// File: rtl/apb_requester_if.sv
// APB4 bus bundle between the requester (master) and the slave-side register/FIFO block (slave).
interface apb_requester_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   PADDR;
    logic [2:0]          PPROT;
    logic                PSEL;
    logic                PENABLE;
    logic                PWRITE;
    logic [DATA_W-1:0]   PWDATA;
    logic [DATA_W/8-1:0] PSTRB;
    logic                PREADY;
    logic [DATA_W-1:0]   PRDATA;
    logic                PSLVERR;

    modport master (
        output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_requester.sv
// APB4 requester: turns one valid/ready command at a time into a SETUP/ACCESS transfer
// and returns read data, PSLVERR or a timeout on a valid/ready response port.
module apb_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,   // 8, 16 or 32
    parameter int TIMEOUT = 16    // 0 disables the timeout
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    input  logic [2:0]          cmd_prot,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_slverr,
    output logic                rsp_timeout,
    apb_requester_if.master     apb
);
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    localparam bit TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    // Count value on the edge before it would reach TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_hit;

    assign timeout_hit = TIMEOUT_EN && (wait_cnt == CNT_LAST);

    // NOTE: cmd_ready is decoded from state and gated by PRESET so no command can be
    // accepted on the very edge that resets the block.
    assign cmd_ready = (state == IDLE) && !PRESET;

    // NOTE: every state and output register below uses non-blocking assignment so all
    // of them update together from values sampled before the edge.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            apb.PADDR   <= '0;
            apb.PPROT   <= '0;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            apb.PWRITE  <= 1'b0;
            apb.PWDATA  <= '0;
            apb.PSTRB   <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        apb.PADDR  <= cmd_addr;
                        apb.PPROT  <= cmd_prot;
                        apb.PWRITE <= cmd_write;
                        apb.PWDATA <= cmd_wdata;
                        apb.PSTRB  <= cmd_write ? cmd_strb : '0;
                        apb.PSEL   <= 1'b1;
                        state      <= SETUP;
                    end
                end

                SETUP: begin
                    apb.PENABLE <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= ACCESS;
                end

                ACCESS: begin
                    // PREADY takes priority over a timeout landing on the same edge.
                    if (apb.PREADY) begin
                        rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
                        rsp_slverr  <= apb.PSLVERR;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        rsp_rdata   <= '0;
                        rsp_slverr  <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        apb.PSEL    <= 1'b0;
                        apb.PENABLE <= 1'b0;
                        state       <= RESP;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule
